// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and flag helpers for the ALU execution unit.
package alu_pkg;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_AND     = 3'b010;
  localparam logic [2:0] OP_OR      = 3'b011;
  localparam logic [2:0] OP_XOR     = 3'b100;
  localparam logic [2:0] OP_NOT     = 3'b101;
  localparam logic [2:0] OP_SHL     = 3'b110;
  localparam logic [2:0] OP_SHR_MUL = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Two's-complement overflow of A+B given the sign bits of A, B and the sum.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  // Two's-complement overflow of A-B given the sign bits of A, B and the difference.
  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: pulse start with operands, done is high
// during the WIDTH-th cycle after start, and product is valid while done is high.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               running;

  // Partial-product accumulation for the current multiplier bit.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  // The last step's sum is handed out combinationally so the result lands exactly WIDTH cycles after start.
  assign done    = running && (cnt == CW'(1));
  assign product = acc_next;

  // Operand load on start, then one shift-add step per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      mcand   <= {{WIDTH{1'b0}}, a};
      acc     <= '0;
      mplier  <= b;
      cnt     <= CW'(WIDTH);
      running <= 1'b1;
    end else if (running) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution unit: accepts one operation per valid/ready transfer and
// returns a registered result with carry/zero/overflow flags.
// Optional feature macro: ALU_MUL_EN (opcode 111 becomes a WIDTH-cycle unsigned MUL).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             busy
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_ovf;
  logic             accept;
  logic             start_mul;

`ifdef ALU_MUL_EN
  state_t             state;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign start_mul = accept && (in_sel == OP_SHR_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_mul),
    .a       (in_a),
    .b       (in_b),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  // Without the multiplier the unit never leaves IDLE, so ready is pure output backpressure.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign start_mul = 1'b0;
`endif

  assign sum  = {1'b0, in_a} + {1'b0, in_b};
  assign diff = {1'b0, in_a} - {1'b0, in_b};

  // Single-cycle opcode decode and flag generation.
  always_comb begin
    r_res   = '0;
    r_carry = 1'b0;
    r_ovf   = 1'b0;
    unique case (in_sel)
      OP_ADD: begin
        r_res   = sum[WIDTH-1:0];
        r_carry = sum[WIDTH];
        r_ovf   = add_ovf(in_a[WIDTH-1], in_b[WIDTH-1], sum[WIDTH-1]);
      end
      OP_SUB: begin
        r_res   = diff[WIDTH-1:0];
        r_carry = diff[WIDTH];
        r_ovf   = sub_ovf(in_a[WIDTH-1], in_b[WIDTH-1], diff[WIDTH-1]);
      end
      OP_AND: r_res = in_a & in_b;
      OP_OR:  r_res = in_a | in_b;
      OP_XOR: r_res = in_a ^ in_b;
      OP_NOT: r_res = ~in_a;
      OP_SHL: begin
        r_res   = {in_a[WIDTH-2:0], 1'b0};
        r_carry = in_a[WIDTH-1];
      end
      OP_SHR_MUL: begin
`ifndef ALU_MUL_EN
        r_res   = {1'b0, in_a[WIDTH-1:1]};
        r_carry = in_a[0];
`endif
      end
      default: ;
    endcase
  end

  // Output register (doubles as the hold stage) and FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_zero   <= 1'b0;
      out_ovf    <= 1'b0;
      busy       <= 1'b0;
`ifdef ALU_MUL_EN
      state      <= ST_IDLE;
`endif
    end else begin
      if (accept && !start_mul) begin
        out_valid  <= 1'b1;
        out_result <= r_res;
        out_carry  <= r_carry;
        out_zero   <= (r_res == '0);
        out_ovf    <= r_ovf;
`ifdef ALU_MUL_EN
      end else if (mul_done) begin
        out_valid  <= 1'b1;
        out_result <= mul_prod[WIDTH-1:0];
        out_carry  <= |mul_prod[2*WIDTH-1:WIDTH];
        out_zero   <= (mul_prod[WIDTH-1:0] == '0);
        out_ovf    <= 1'b0;
`endif
      end else if (out_valid && out_ready) begin
        out_valid  <= 1'b0;
        out_result <= '0;
        out_carry  <= 1'b0;
        out_zero   <= 1'b0;
        out_ovf    <= 1'b0;
      end
`ifdef ALU_MUL_EN
      unique case (state)
        ST_IDLE: if (start_mul) begin
          state <= ST_MUL;
          busy  <= 1'b1;
        end
        ST_MUL: if (mul_done) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit (WIDTH=4); build with +define+ALU_MUL_EN for the MUL variant.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [2:0] in_sel;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_carry;
  logic       out_zero;
  logic       out_ovf;
  logic       busy;

  typedef struct {
    logic [3:0] res;
    logic       c;
    logic       z;
    logic       v;
    int         acc;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  alu_exec_unit #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc equals the number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one op starting at a falling edge; returns at the falling edge after acceptance.
  // lat = number of rising edges between the accept edge and the edge that presents the result.
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                       input logic [3:0] r, input logic c, input logic v,
                       input int lat, input bit push);
    exp_t e;
    in_a = a;
    in_b = b;
    in_sel = sel;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (in_ready) begin
        if (push) begin
          e.res = r;
          e.c   = c;
          e.z   = (r == 4'd0);
          e.v   = v;
          e.acc = cyc + 1;
          e.lat = lat;
          sb.push_back(e);
        end
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout actual=no_accept required=accept sel=%0b", sel);
  endtask

  // Monitor: compares each newly presented result against the scoreboard head.
  initial begin : monitor
    logic fresh;
    exp_t e;
    fresh = 1'b1;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        fresh = 1'b1;
      end else if (out_valid) begin
        if (fresh) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%0h required=none", out_result);
          end else begin
            e = sb.pop_front();
            chk("result", out_result, e.res);
            chk("carry", out_carry, e.c);
            chk("zero", out_zero, e.z);
            chk("ovf", out_ovf, e.v);
            chk("latency", cyc - e.acc, e.lat);
          end
        end
        fresh = out_ready;
      end else begin
        fresh = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int t0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_sel = '0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_flags", {out_carry, out_zero, out_ovf}, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back single-cycle ops, A=0101 B=0011.
    issue(4'b0101, 4'b0011, OP_ADD, 4'b1000, 1'b0, 1'b1, 0, 1'b1);
    issue(4'b0101, 4'b0011, OP_SUB, 4'b0010, 1'b0, 1'b0, 0, 1'b1);
    issue(4'b0101, 4'b0011, OP_AND, 4'b0001, 1'b0, 1'b0, 0, 1'b1);
    issue(4'b0101, 4'b0011, OP_OR,  4'b0111, 1'b0, 1'b0, 0, 1'b1);
    issue(4'b0101, 4'b0011, OP_XOR, 4'b0110, 1'b0, 1'b0, 0, 1'b1);
    issue(4'b0011, 4'b0101, OP_SUB, 4'b1110, 1'b1, 1'b0, 0, 1'b1);
    issue(4'b0101, 4'b0101, OP_XOR, 4'b0000, 1'b0, 1'b0, 0, 1'b1);
    issue(4'b0101, 4'b0000, OP_NOT, 4'b1010, 1'b0, 1'b0, 0, 1'b1);
    issue(4'b1101, 4'b0000, OP_SHL, 4'b1010, 1'b1, 1'b0, 0, 1'b1);
    issue(4'b1001, 4'b1001, OP_ADD, 4'b0010, 1'b1, 1'b1, 0, 1'b1);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Backpressure: result held three cycles, then release with a new op pending.
    out_ready = 1'b0;
    issue(4'b0110, 4'b0001, OP_ADD, 4'b0111, 1'b0, 1'b0, 0, 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("hold_valid", out_valid, 1);
      chk("hold_result", out_result, 4'b0111);
      chk("hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    t0 = cyc;
    issue(4'b1001, 4'b0110, OP_OR, 4'b1111, 1'b0, 1'b0, 0, 1'b1);
    chk("same_edge_accept", cyc - t0, 1);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

`ifdef ALU_MUL_EN
    issue(4'b0101, 4'b0011, OP_SHR_MUL, 4'b1111, 1'b0, 1'b0, 4, 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("mul_busy", busy, 1);
      chk("mul_in_ready", in_ready, 0);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    issue(4'b0111, 4'b0011, OP_SHR_MUL, 4'b0101, 1'b1, 1'b0, 4, 1'b1);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("mul_busy_after", busy, 0);

    // Reset in the middle of a multiply: aborted, nothing emitted.
    issue(4'b0111, 4'b0111, OP_SHR_MUL, 4'b0000, 1'b0, 1'b0, 4, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_result", out_result, 0);
    chk("midrst_flags", {out_carry, out_zero, out_ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("postrst_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #2;
      chk("postrst_no_stale", out_valid, 0);
    end
`else
    issue(4'b0101, 4'b0000, OP_SHR_MUL, 4'b0010, 1'b1, 1'b0, 0, 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("shr_busy", busy, 0);
      @(negedge clk);
    end
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d_pending required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
